// File: rtl/dm_write_tracer.sv
`default_nettype none
// ============================================================================
// Module   : dm_write_tracer
// Brief    : Snoops data-memory stores into a show-ahead FIFO and drains them
//            over a valid/ready trace stream; dump freezes capture and flushes.
// Revision : 1.0 - initial release
// ============================================================================
module dm_write_tracer #(
    parameter int N     = 64,
    parameter int DEPTH = 16,
    parameter int SEQ_W = 16
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     DM_writeEnable,
    input  logic [N-1:0]             DM_addr,
    input  logic [N-1:0]             DM_writeData,
    input  logic                     dump,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [N-1:0]             trace_addr,
    output logic [N-1:0]             trace_data,
    output logic [SEQ_W-1:0]         trace_seq,
    output logic                     trace_last,
    output logic [SEQ_W-1:0]         overflow_cnt,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     done
);

    localparam int            PW           = $clog2(DEPTH);
    localparam logic [PW:0]   c_full_count = (PW+1)'(DEPTH);
    localparam logic [PW:0]   c_one        = (PW+1)'(1);

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [N-1:0]       r_mem_addr [DEPTH];
    logic [N-1:0]       r_mem_data [DEPTH];
    logic [SEQ_W-1:0]   r_mem_seq  [DEPTH];

    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [PW:0]        r_count;
    logic [SEQ_W-1:0]   r_seq;
    logic [SEQ_W-1:0]   r_ovf;
    logic               r_dump_q;

    logic               w_empty;
    logic               w_full;
    logic               w_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_ovf_inc;
    logic               w_seq_inc;
    logic               w_dump_edge;
    logic               w_last;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_full_count);
    assign w_valid     = !w_empty && (r_state != ST_DONE);
    assign w_pop       = w_valid && trace_ready;
    assign w_dump_edge = dump & ~r_dump_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= ST_CAPTURE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_ovf_inc    = 1'b0;
        w_seq_inc    = 1'b0;
        w_last       = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            ST_CAPTURE: begin
                // A full FIFO still accepts a store when the head leaves this cycle.
                if (DM_writeEnable) begin
                    w_seq_inc = 1'b1;
                    if (!w_full || w_pop) begin
                        w_push = 1'b1;
                    end else begin
                        w_ovf_inc = 1'b1;
                    end
                end
                if (w_dump_edge) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (DM_writeEnable) begin
                    w_seq_inc = 1'b1;
                    w_ovf_inc = 1'b1;
                end
                w_last = w_valid && (r_count == c_one);
                if (w_empty || ((r_count == c_one) && w_pop)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: begin
                w_state_next = ST_CAPTURE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_seq    <= '0;
            r_ovf    <= '0;
            r_dump_q <= 1'b0;
        end else begin
            r_dump_q <= dump;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_seq_inc) begin
                r_seq <= r_seq + 1'b1;
            end
            if (w_ovf_inc && (r_ovf != '1)) begin
                r_ovf <= r_ovf + 1'b1;
            end
        end
    end

    // Storage needs no reset: an empty FIFO masks the head outputs to zero.
    always_ff @(posedge CLOCK_50) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= DM_addr;
            r_mem_data[r_wr_ptr] <= DM_writeData;
            r_mem_seq[r_wr_ptr]  <= r_seq;
        end
    end

    assign trace_valid  = w_valid;
    assign trace_last   = w_last;
    assign trace_addr   = w_empty ? '0 : r_mem_addr[r_rd_ptr];
    assign trace_data   = w_empty ? '0 : r_mem_data[r_rd_ptr];
    assign trace_seq    = w_empty ? '0 : r_mem_seq[r_rd_ptr];
    assign overflow_cnt = r_ovf;
    assign count        = r_count;

endmodule
`default_nettype wire

// File: tb/tb_dm_write_tracer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_write_tracer
// Brief    : Randomised scoreboard bench for dm_write_tracer against a
//            queue-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_write_tracer;

    localparam int N     = 64;
    localparam int DEPTH = 16;
    localparam int SEQ_W = 16;

    logic                   CLOCK_50 = 1'b0;
    logic                   reset    = 1'b1;
    logic                   we       = 1'b0;
    logic [N-1:0]           addr     = '0;
    logic [N-1:0]           wdata    = '0;
    logic                   dump     = 1'b0;
    logic                   ready    = 1'b0;
    logic                   trace_valid;
    logic [N-1:0]           trace_addr;
    logic [N-1:0]           trace_data;
    logic [SEQ_W-1:0]       trace_seq;
    logic                   trace_last;
    logic [SEQ_W-1:0]       overflow_cnt;
    logic [$clog2(DEPTH):0] count;
    logic                   busy;
    logic                   done;

    always #5 CLOCK_50 = ~CLOCK_50;

    dm_write_tracer #(.N(N), .DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .DM_writeEnable (we),
        .DM_addr        (addr),
        .DM_writeData   (wdata),
        .dump           (dump),
        .trace_valid    (trace_valid),
        .trace_ready    (ready),
        .trace_addr     (trace_addr),
        .trace_data     (trace_data),
        .trace_seq      (trace_seq),
        .trace_last     (trace_last),
        .overflow_cnt   (overflow_cnt),
        .count          (count),
        .busy           (busy),
        .done           (done)
    );

    typedef struct {
        logic [N-1:0]     addr;
        logic [N-1:0]     data;
        logic [SEQ_W-1:0] seq;
    } rec_t;

    rec_t exp_q[$];

    // Model: occupancy, phase (0 capture, 1 drain, 2 done), counters.
    int               m_occ;
    int               m_phase;
    logic [SEQ_W-1:0] m_seq;
    logic [SEQ_W-1:0] m_ovf;
    logic             m_dump_prev;

    // Expected observable state for the cycle currently in progress.
    bit               chk_en = 1'b0;
    logic             e_valid;
    logic             e_last;
    logic             e_busy;
    logic             e_done;
    int               e_count;
    logic [SEQ_W-1:0] e_ovf;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_occ       = 0;
        m_phase     = 0;
        m_seq       = '0;
        m_ovf       = '0;
        m_dump_prev = 1'b0;
        exp_q.delete();
    endtask

    task automatic step(input logic i_rst, input logic i_we, input logic [N-1:0] i_a,
                        input logic [N-1:0] i_d, input logic i_rdy, input logic i_dump);
        logic pop;
        int   nxt;
        rec_t r;
        @(posedge CLOCK_50);
        #1;
        reset = i_rst;
        we    = i_we;
        addr  = i_a;
        wdata = i_d;
        ready = i_rdy;
        dump  = i_dump;
        if (i_rst) begin
            model_reset();
        end else begin
            e_valid = (m_occ > 0) && (m_phase != 2);
            e_last  = e_valid && (m_occ == 1) && (m_phase == 1);
            e_count = m_occ;
            e_busy  = (m_phase != 2);
            e_done  = (m_phase == 2);
            e_ovf   = m_ovf;
            chk_en  = 1'b1;
            pop     = e_valid && i_rdy;
            nxt     = m_phase;
            if (m_phase == 0) begin
                if (i_we) begin
                    if (m_occ < DEPTH || pop) begin
                        r.addr = i_a;
                        r.data = i_d;
                        r.seq  = m_seq;
                        exp_q.push_back(r);
                        m_occ++;
                    end else if (m_ovf != {SEQ_W{1'b1}}) begin
                        m_ovf++;
                    end
                    m_seq++;
                end
                if (i_dump && !m_dump_prev) nxt = 1;
            end else if (m_phase == 1) begin
                if (i_we) begin
                    if (m_ovf != {SEQ_W{1'b1}}) m_ovf++;
                    m_seq++;
                end
            end
            if (pop) m_occ--;
            if (m_phase == 1 && m_occ == 0) nxt = 2;
            m_phase     = nxt;
            m_dump_prev = i_dump;
        end
    endtask

    function automatic logic [N-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Monitor: compares the DUT against the scoreboard mid-cycle.
    always @(negedge CLOCK_50) begin
        if (chk_en && !reset) begin
            chk("trace_valid", 64'(trace_valid), 64'(e_valid));
            chk("count", 64'(count), 64'(e_count));
            chk("overflow_cnt", 64'(overflow_cnt), 64'(e_ovf));
            chk("busy", 64'(busy), 64'(e_busy));
            chk("done", 64'(done), 64'(e_done));
            chk("trace_last", 64'(trace_last), 64'(e_last));
            if (e_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL scoreboard_empty: got empty queue required a record (t=%0t)", $time);
                end else begin
                    chk("trace_addr", trace_addr, exp_q[0].addr);
                    chk("trace_data", trace_data, exp_q[0].data);
                    chk("trace_seq", 64'(trace_seq), 64'(exp_q[0].seq));
                    if (ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_addr", trace_addr, 64'd0);
                chk("idle_data", trace_data, 64'd0);
                chk("idle_seq", 64'(trace_seq), 64'd0);
            end
        end
    end

    initial begin
        int k;
        model_reset();
        repeat (3) step(1, 0, '0, '0, 0, 0);

        // Three back-to-back stores, sink always ready.
        step(0, 1, 64'h10, 64'hAA, 1, 0);
        step(0, 1, 64'h18, 64'hBB, 1, 0);
        step(0, 1, 64'h20, 64'hCC, 1, 0);
        repeat (3) step(0, 0, '0, '0, 1, 0);

        // Overfill with the sink stalled, then dump and drain.
        step(1, 0, '0, '0, 0, 0);
        repeat (20) step(0, 1, rnd64(), rnd64(), 0, 0);
        step(0, 0, '0, '0, 1, 1);
        k = 0;
        while (m_phase != 2 && k < 40) begin
            step(0, 0, '0, '0, 1, 1);
            k++;
        end
        chk("drain1_timeout", 64'(k < 40), 64'd1);
        repeat (2) step(0, 1, rnd64(), rnd64(), 1, 0);

        // Full FIFO with simultaneous pop and push.
        step(1, 0, '0, '0, 0, 0);
        repeat (16) step(0, 1, rnd64(), rnd64(), 0, 0);
        step(0, 1, rnd64(), rnd64(), 1, 0);
        repeat (3) step(0, 0, '0, '0, 1, 0);

        // Backpressure toggling with two pending records.
        step(1, 0, '0, '0, 0, 0);
        repeat (2) step(0, 1, rnd64(), rnd64(), 0, 0);
        step(0, 0, '0, '0, 0, 0);
        step(0, 0, '0, '0, 1, 0);
        step(0, 0, '0, '0, 0, 0);
        step(0, 0, '0, '0, 0, 0);
        step(0, 0, '0, '0, 1, 0);
        step(0, 0, '0, '0, 1, 0);

        // Dump on an empty FIFO, store while draining.
        step(1, 0, '0, '0, 0, 0);
        step(0, 0, '0, '0, 1, 1);
        step(0, 1, rnd64(), rnd64(), 1, 1);
        repeat (3) step(0, 1, rnd64(), rnd64(), 1, 0);

        // Reset mid-drain with five pending records.
        step(1, 0, '0, '0, 0, 0);
        repeat (5) step(0, 1, rnd64(), rnd64(), 0, 0);
        step(0, 0, '0, '0, 0, 1);
        step(0, 0, '0, '0, 0, 1);
        step(1, 0, '0, '0, 0, 1);
        step(0, 0, '0, '0, 0, 0);
        step(0, 0, '0, '0, 1, 0);

        // Randomised traffic with occasional dumps and resets.
        for (int i = 0; i < 1500; i++) begin
            logic r_rst;
            logic r_dump;
            r_rst  = ($urandom_range(0, 299) == 0) || (m_phase == 2 && $urandom_range(0, 7) == 0);
            r_dump = ($urandom_range(0, 39) == 0) ? ~dump : dump;
            step(r_rst, 1'($urandom_range(0, 1)), rnd64(), rnd64(),
                 1'($urandom_range(0, 4) > 1), r_dump);
        end

        // Final flush: every issued record must have been delivered.
        step(0, 0, '0, '0, 1, 0);
        step(0, 0, '0, '0, 1, 1);
        k = 0;
        while (m_phase != 2 && k < 64) begin
            step(0, 0, '0, '0, 1, 1);
            k++;
        end
        chk("final_drain_timeout", 64'(k < 64), 64'd1);
        repeat (2) step(0, 0, '0, '0, 1, 1);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dm_write_tracer.md
Name: dm_write_tracer

Overview:
- Sits directly downstream of processor_arm. Snoops the data-memory write port (DM_writeEnable, DM_addr, DM_writeData) and records every store in a FIFO.
- Drains the stores over a valid/ready trace stream to the simulation harness or a host link.
- The dump input freezes capture and flushes the remaining records, so the end-of-run memory-write history is lossless and ordered.

Parameters:
- N, 64, data/address width; matches the processor datapath.
- DEPTH, 16, FIFO entries; must be a power of two and at least 2.
- SEQ_W, 16, width of the write sequence number and of the overflow counter.

Ports:
- CLOCK_50  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- DM_writeEnable  in  1  processor store strobe, sampled once per cycle.
- DM_addr  in  N  store address.
- DM_writeData  in  N  store data.
- dump  in  1  level input; a 0->1 edge starts the drain.
- trace_valid  out  1  a record is presented.
- trace_ready  in  1  sink accepts the record.
- trace_addr  out  N  recorded address.
- trace_data  out  N  recorded data.
- trace_seq  out  SEQ_W  sequence number of the recorded write.
- trace_last  out  1  the presented record is the final one of the drain.
- overflow_cnt  out  SEQ_W  number of dropped writes; saturates at all-ones.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- busy  out  1  high in CAPTURE and DRAIN.
- done  out  1  high in DONE.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - FIFO emptied; rd/wr pointers = 0; count = 0.
  - seq counter = 0; overflow_cnt = 0; dump edge register = 0.
  - State = CAPTURE; trace_valid = 0, trace_last = 0, busy = 1, done = 0.
  - trace_addr/trace_data/trace_seq = 0 while the FIFO is empty.
- Reset mid-drain discards all pending records; no partial handshake survives.
- FIFO: show-ahead. Head entry is driven combinationally from the storage array.
  - trace_valid = (count != 0) and state != DONE.
  - Pop when trace_valid && trace_ready.
  - While trace_valid && !trace_ready, trace_addr/data/seq/last stay stable.
- CAPTURE:
  - Each edge with DM_writeEnable=1 pushes {seq, DM_addr, DM_writeData}, then seq increments, wrapping modulo 2^SEQ_W.
  - seq increments on every observed write, including dropped ones, so gaps in trace_seq expose drops.
  - Full with no pop: push dropped, overflow_cnt += 1 (saturating).
  - Full with a simultaneous pop: push accepted; count unchanged.
  - Empty with a simultaneous push: no pop occurs; the record appears with trace_valid in the next cycle (1-cycle latency).
  - Pointers wrap naturally at DEPTH.
- dump edge: dump_q is registered; edge = dump & ~dump_q.
  - Edge in CAPTURE -> DRAIN at the next edge.
  - A write sampled in the same cycle as the edge is still captured.
- DRAIN:
  - No pushes. Any DM_writeEnable=1 increments overflow_cnt (saturating) and seq.
  - Pops continue as normal.
  - trace_last = trace_valid && count == 1.
  - Transition to DONE at the edge where count becomes 0, or at the first DRAIN cycle if already empty.
- DONE:
  - trace_valid = 0, busy = 0, done = 1.
  - Further writes and dump edges are ignored; overflow_cnt and seq are frozen.
  - Exits only via reset.
- Further dump edges in DRAIN are ignored.
- Arithmetic: count updates as +1 (push only), -1 (pop only), or unchanged. No subtraction underflow is possible because a pop requires count != 0.

Test Plan:
- Reset, then 3 stores (0x10/0xAA, 0x18/0xBB, 0x20/0xCC) on consecutive cycles, trace_ready=1 -> records delivered in order with seq 0, 1, 2; each appears 1 cycle after its store; overflow_cnt=0; count returns to 0.
- trace_ready=0, then 20 consecutive stores with DEPTH=16 -> count=16, overflow_cnt=4; then ready=1 + dump -> 16 records with seq 0..15; trace_last high only on seq 15; done=1 afterwards.
- Full FIFO, ready=1 and a store in the same cycle -> store accepted, count stays 16, overflow_cnt unchanged.
- ready toggled 1/0/1 with 2 pending records -> outputs stable while ready=0; no duplicate or lost records.
- dump with an empty FIFO -> DRAIN for 1 cycle, then DONE; trace_valid never asserted. A store during DRAIN -> overflow_cnt=1.
- reset asserted mid-drain with 5 pending -> next cycle count=0, trace_valid=0, state=CAPTURE, seq=0, overflow_cnt=0.
